// File: rtl/mem_arbiter.sv
// Purpose : fetch/data arbiter and fixed IDLE->ACCESS->DONE sequencer for one single-port memory.
// Latency : request seen in IDLE cycle N -> memory access in N+1 -> done pulse in N+2 -> IDLE in N+3.
// Backpres: requesters hold req (and operands) until their done pulse; a loser simply waits in IDLE.
//
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   f_req/f_addr       - fetch read request; f_done pulse with f_rdata
//   d_req/d_we/d_addr/d_wdata - data read/write request; d_done pulse with d_rdata (reads)
//   mem_address/mem_write_data/mem_write_enable - to memory, non-zero only in ACCESS
//   mem_read_data      - combinational read data from memory
//   busy               - high whenever the sequencer is not IDLE
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_done,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Owner encoding: 0 = fetch, 1 = data.
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Operands of the access in flight, captured at grant time.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  acc_t                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Arbitration: a lone requester wins; on a tie the side that did not
  // own the previous access wins, so contention alternates.
  logic grant_any;
  logic grant_d;

  always_comb begin
    grant_any = f_req | d_req;
    grant_d   = d_req & (~f_req | (last_owner_q == OWN_F));
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs, decoded only from registered state (never from req)
  // ---------------------------------------------------------------------
  always_comb begin
    f_done           = 1'b0;
    d_done           = 1'b0;
    busy             = (state_q != ST_IDLE);
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        mem_address      = acc_q.addr;
        mem_write_data   = acc_q.wdata;
        mem_write_enable = acc_q.we;
      end
      ST_DONE: begin
        f_done = (owner_q == OWN_F);
        d_done = (owner_q == OWN_D);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-values: grant latch, read-data capture, fairness history
  // ---------------------------------------------------------------------
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    acc_d        = acc_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;

    if (state_q == ST_IDLE && grant_any) begin
      if (grant_d) begin
        owner_d     = OWN_D;
        acc_d.we    = d_we;
        acc_d.addr  = d_addr;
        acc_d.wdata = d_wdata;
      end else begin
        // Fetch is always a read; its write path is forced quiet.
        owner_d     = OWN_F;
        acc_d.we    = 1'b0;
        acc_d.addr  = f_addr;
        acc_d.wdata = '0;
      end
    end

    if (state_q == ST_ACCESS) begin
      last_owner_d = owner_q;
      if (owner_q == OWN_F) begin
        f_rdata_d = mem_read_data;
      end else if (!acc_q.we) begin
        // A data write leaves the previous read value in place.
        d_rdata_d = mem_read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_F;
      last_owner_q <= OWN_F;   // first tie after reset goes to data
      acc_q        <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      acc_q        <= acc_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter with a behavioural single-port memory.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpres: requests are held until the done pulse, then dropped on the following edge.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .f_req            (f_req),
    .f_addr           (f_addr),
    .f_done           (f_done),
    .f_rdata          (f_rdata),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_done           (d_done),
    .d_rdata          (d_rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
  );

  // Behavioural memory: 256 words, write on the clock edge, combinational read.
  logic [DW-1:0] mem [0:255];
  logic          mem_hi;

  assign mem_hi        = |mem_address[AW-1:8];
  assign mem_read_data = mem_hi ? '0 : mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".busy"},   64'(busy), 64'd0);
    chk({tag, ".f_done"}, 64'(f_done), 64'd0);
    chk({tag, ".d_done"}, 64'(d_done), 64'd0);
    chk({tag, ".f_rdata"}, 64'(f_rdata), 64'h0);
    chk({tag, ".d_rdata"}, 64'(d_rdata), 64'h0);
    chk({tag, ".mem_we"}, 64'(mem_write_enable), 64'd0);
    chk({tag, ".mem_addr"}, 64'(mem_address), 64'h0);
    chk({tag, ".mem_wdata"}, 64'(mem_write_data), 64'h0);
  endtask

  // One uncontended access from IDLE, checked cycle by cycle.
  task automatic run_access(input string tag, input bit is_d, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_rd);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    tick();   // ACCESS
    chk({tag, ".acc_busy"}, 64'(busy), 64'd1);
    chk({tag, ".acc_we"},   64'(mem_write_enable), 64'(we));
    chk({tag, ".acc_addr"}, 64'(mem_address), 64'(addr));
    chk({tag, ".acc_wdata"}, 64'(mem_write_data), we ? 64'(wdata) : 64'h0);
    chk({tag, ".acc_nodone"}, 64'({f_done, d_done}), 64'd0);
    tick();   // DONE
    chk({tag, ".done"}, 64'({f_done, d_done}), is_d ? 64'b01 : 64'b10);
    chk({tag, ".done_we"}, 64'(mem_write_enable), 64'd0);
    chk({tag, ".done_addr"}, 64'(mem_address), 64'h0);
    if (is_d) chk({tag, ".d_rdata"}, 64'(d_rdata), 64'(exp_rd));
    else      chk({tag, ".f_rdata"}, 64'(f_rdata), 64'(exp_rd));
    tick();   // back to IDLE; requester drops on the edge that saw done
    f_req = 1'b0;
    d_req = 1'b0;
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk({tag, ".idle_done"}, 64'({f_done, d_done}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    apply_reset();
    chk_reset_state("rst");

    // Data write 0x66=0x36, then fetch reads it back
    run_access("dwr66", 1'b1, 1'b1, 32'h66, 32'h36, 32'h0);
    run_access("frd66", 1'b0, 1'b0, 32'h66, 32'h0, 32'h36);

    // Data write/read must not disturb fetch data; write keeps d_rdata
    run_access("dwr55", 1'b1, 1'b1, 32'h55, 32'h99, 32'h0);
    run_access("drd55", 1'b1, 1'b0, 32'h55, 32'h0, 32'h99);
    chk("keep_f_rdata", 64'(f_rdata), 64'h36);
    run_access("dwr77", 1'b1, 1'b1, 32'h77, 32'h1234, 32'h99);

    // Reset during ACCESS of a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h77;
    tick();
    chk("mid.acc_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    d_req = 1'b0;
    tick();
    chk_reset_state("mid");
    reset = 1'b0;
    tick();
    chk("mid.after_busy", 64'(busy), 64'd0);
    chk("mid.after_done", 64'({f_done, d_done}), 64'd0);

    // Simultaneous first requests after reset: data first, fetch second
    f_req = 1'b1; f_addr = 32'h55;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h77;
    tick();
    chk("tie.c1_addr", 64'(mem_address), 64'h77);
    tick();
    chk("tie.c2_done", 64'({f_done, d_done}), 64'b01);
    chk("tie.c2_drd", 64'(d_rdata), 64'h1234);
    tick();
    d_req = 1'b0;
    chk("tie.c3_busy", 64'(busy), 64'd0);
    tick();
    chk("tie.c4_addr", 64'(mem_address), 64'h55);
    tick();
    chk("tie.c5_done", 64'({f_done, d_done}), 64'b10);
    chk("tie.c5_frd", 64'(f_rdata), 64'h99);
    tick();
    f_req = 1'b0;

    // Sustained contention: last owner is fetch, so d,f,d,f every 3 cycles
    f_req = 1'b1; f_addr = 32'h66;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h77;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0] exp_dn;
      tick();
      case (k)
        2, 8:    exp_dn = 2'b01;
        5, 11:   exp_dn = 2'b10;
        default: exp_dn = 2'b00;
      endcase
      chk($sformatf("cont.k%0d", k), 64'({f_done, d_done}), 64'(exp_dn));
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk("cont.f_rdata", 64'(f_rdata), 64'h36);
    chk("cont.d_rdata", 64'(d_rdata), 64'h1234);
    tick();

    // Request dropped in ACCESS still completes
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h55;
    tick();
    d_req = 1'b0;
    tick();
    chk("drop.done", 64'({f_done, d_done}), 64'b01);
    chk("drop.d_rdata", 64'(d_rdata), 64'h99);
    tick();
    chk("drop.idle", 64'(busy), 64'd0);

    // Idle: nothing moves for 10 cycles
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle.k%0d", k),
          64'({busy, mem_write_enable, f_done, d_done}), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the shared single-port `memory` block of the execution-cycle datapath. It accepts read requests from the instruction-fetch stage and read/write requests from the data (load/store) stage, and grants the memory to one requester at a time. Each granted request runs as one fixed three-state access. The requester receives a one-cycle `done` pulse with registered read data.

## Interface
- `ADDR_WIDTH`, 32, width of all address buses
- `DATA_WIDTH`, 32, width of all data buses

- `clk`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `f_req`  input  1  fetch request; held high with `f_addr` stable until `f_done`
- `f_addr`  input  ADDR_WIDTH  fetch read address
- `f_done`  output  1  one-cycle pulse: fetch access complete, `f_rdata` valid
- `f_rdata`  output  DATA_WIDTH  fetch read data, held until next fetch completion
- `d_req`  input  1  data request; held high with `d_we/d_addr/d_wdata` stable until `d_done`
- `d_we`  input  1  1 = write, 0 = read
- `d_addr`  input  ADDR_WIDTH  data address
- `d_wdata`  input  DATA_WIDTH  data write value
- `d_done`  output  1  one-cycle pulse: data access complete, `d_rdata` valid on reads
- `d_rdata`  output  DATA_WIDTH  data read data, held until next data read completion
- `mem_address`  output  ADDR_WIDTH  to memory `address`
- `mem_write_data`  output  DATA_WIDTH  to memory `write_data`
- `mem_write_enable`  output  1  to memory `write_enable`
- `mem_read_data`  input  DATA_WIDTH  from memory `mem_read_data`, combinational on `mem_address`
- `busy`  output  1  high whenever the state is not IDLE

## Operation
- States are IDLE, ACCESS and DONE. Internal registers: `owner` (0 = fetch, 1 = data), `last_owner`, and latched `addr`, `wdata` and `we`.
- **IDLE:** `f_req` and `d_req` are sampled.
  - If only one request is high, that requester wins.
  - If both are high, the requester other than `last_owner` wins.
  - On a win, the winner's address/wdata/we are latched (`we` is forced to 0 for fetch), `owner` is set, and the state moves to ACCESS.
  - With no request, the state stays in IDLE.
- **ACCESS:**
  - `mem_address` is driven from `addr`, `mem_write_data` from `wdata`, and `mem_write_enable = we`.
  - At the closing edge:
    - the memory performs the write if `we` = 1;
    - `mem_read_data` is captured into `f_rdata` (owner = fetch) or into `d_rdata` (owner = data, read only);
    - `last_owner` is set to `owner`;
    - the state moves to DONE.
- **DONE:** `f_done` or `d_done` is high according to `owner`. Requests are ignored. The state moves to IDLE.
- Outside ACCESS: `mem_write_enable` = 0 and `mem_address`/`mem_write_data` = 0.
- A data write leaves `d_rdata` unchanged.
- `done` outputs and `busy` are decoded from the state register. They are never combinational from `req`.
- A requester deasserts `req` on the edge at which it samples its `done` high. A `req` still high in the following IDLE cycle is a new request.
- There are no width conversions. Addresses and data pass through unmodified.

## Timing
- **Reset values:** state IDLE, `last_owner` = fetch (the first tie goes to data), `f_done` = `d_done` = 0, `f_rdata` = `d_rdata` = 0, `busy` = 0, all `mem_*` outputs 0.
- **Latency:** a request high in IDLE cycle N gives ACCESS in N+1, `done` in N+2 and IDLE in N+3.
- **Throughput:** one access per 3 cycles. With both requesters held high, grants alternate data, fetch, data, and so on.
- **Reset mid-operation:**
  - The state returns to IDLE on the reset edge, with no `done` pulse.
  - A write whose ACCESS cycle coincides with the reset edge is committed by the memory on that edge. This is permitted, because `we` is decoded from the state held before reset.
  - The read-data registers are cleared.
- **Request dropped early:** a `req` dropped in ACCESS or DONE does not abort the access, and the `done` pulse still occurs.

## Test plan
- **Data write then fetch read:** after reset, `d_req`=1, `d_we`=1, `d_addr`=0x66, `d_wdata`=0x36. Required: `mem_write_enable`=1 only in ACCESS, and `d_done` in cycle +2. Then `f_req` with `f_addr`=0x66. Required: `f_done` in cycle +2 with `f_rdata`=0x36.
- **Simultaneous first requests:** `f_req` and `d_req` rise together after reset, with `d_addr`=0x77 read and `f_addr`=0x55. Required: data is granted first (`d_done` in cycle +2), then fetch (`f_done` in cycle +5).
- **Sustained contention:** both `req` held for 12 cycles, with each requester re-asserting its `req` in the cycle after its own `done`. Required: `done` pulses alternate d, f, d, f, 3 cycles apart, and no requester is granted twice in a row.
- **Reset during ACCESS of a read:** required: no `done`, `busy`=0 the cycle after, and all outputs at their reset values.
- **Data read does not disturb fetch data:** fetch reads 0x66 (=0x36), then data writes 0x55=0x99 and reads it. Required: `d_rdata`=0x99 and `f_rdata` still 0x36.
- **Idle:** no requests for 10 cycles. Required: `busy`=0, `mem_write_enable`=0 and both `done` outputs 0 throughout.
